// File: rtl/oil_slick_controller.sv
// Oil slick scheduler: scrolls, retires and spawns up to NUM_SLOTS slicks,
// shares one bitmap drawer between them and turns contact into skid pulses.
module oil_slick_controller #(
    parameter int NUM_SLOTS    = 4,
    parameter int OBJ_W        = 64,
    parameter int OBJ_H        = 32,
    parameter int SCREEN_H     = 480,
    parameter int ROAD_LEFT    = 192,
    parameter int SPAWN_PERIOD = 90
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 enable,
    input  logic [3:0]           speed,
    input  logic [10:0]          pixelX,
    input  logic [10:0]          pixelY,
    input  logic                 oilCarCollision,
    output logic                 InsideRectangle,
    output logic [10:0]          offsetX,
    output logic [10:0]          offsetY,
    output logic                 skidPulse,
    output logic [NUM_SLOTS-1:0] activeMask,
    output logic                 busy
);

    localparam int SEL_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(SPAWN_PERIOD);
    localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SPAWN_PERIOD - 1);
    localparam logic [11:0]      SCREEN_H12 = 12'(SCREEN_H);
    localparam logic [11:0]      OBJ_W12    = 12'(OBJ_W);
    localparam logic [11:0]      OBJ_H12    = 12'(OBJ_H);
    localparam logic [10:0]      ROAD_LEFT11 = 11'(ROAD_LEFT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        SPAWN  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] idx_next;

    logic [NUM_SLOTS-1:0] active;
    logic [NUM_SLOTS-1:0] hit;
    logic [10:0]          top_x [NUM_SLOTS];
    logic [10:0]          top_y [NUM_SLOTS];
    logic [CNT_W-1:0]     spawn_cnt;
    logic [15:0]          lfsr;

    logic [11:0]      upd_sum;
    logic             free_found;
    logic [SEL_W-1:0] free_idx;

    logic             pix_hit;
    logic [SEL_W-1:0] pix_sel;
    logic [10:0]      pix_ox;
    logic [10:0]      pix_oy;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] sel_d;
    logic             coll_fire;

    // Free-running pseudo-random source for spawn X (taps 16,14,13,11).
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    // Frame sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Frame sequencer: walk every slot once, then one spawn step.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        unique case (state)
            IDLE: begin
                if (startOfFrame && enable) begin
                    state_next = UPDATE;
                    idx_next   = '0;
                end
            end
            UPDATE: begin
                if (idx == LAST_IDX) begin
                    state_next = SPAWN;
                end else begin
                    idx_next = idx + SEL_W'(1);
                end
            end
            SPAWN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy       = (state != IDLE);
    assign activeMask = active;

    // Scrolled position of the slot being updated; 12 bits so 479+15 cannot wrap.
    always_comb begin
        upd_sum = {1'b0, top_y[idx]} + {8'b0, speed};
    end

    // Lowest-index free slot, seen after this frame's retirements.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!free_found && !active[SEL_W'(i)]) begin
                free_found = 1'b1;
                free_idx   = SEL_W'(i);
            end
        end
    end

    // A collision only counts once per slick lifetime.
    always_comb begin
        coll_fire = oilCarCollision && enable && active[sel_d] && !hit[sel_d];
    end

    // Slot table: collision marking, then scroll/retire, then spawn.
    // Later assignments take priority, so a retire or respawn clears a hit set in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            active    <= '0;
            hit       <= '0;
            spawn_cnt <= '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                top_x[SEL_W'(i)] <= '0;
                top_y[SEL_W'(i)] <= '0;
            end
        end else begin
            if (coll_fire) begin
                hit[sel_d] <= 1'b1;
            end
            if (state == UPDATE && active[idx]) begin
                if (upd_sum >= SCREEN_H12) begin
                    active[idx] <= 1'b0;
                    hit[idx]    <= 1'b0;
                end else begin
                    top_y[idx] <= upd_sum[10:0];
                end
            end
            if (state == SPAWN) begin
                if (spawn_cnt == CNT_LAST) begin
                    spawn_cnt <= '0;
                    if (free_found) begin
                        active[free_idx] <= 1'b1;
                        hit[free_idx]    <= 1'b0;
                        top_y[free_idx]  <= '0;
                        top_x[free_idx]  <= ROAD_LEFT11 + {3'b000, lfsr[7:0]};
                    end
                end else begin
                    spawn_cnt <= spawn_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Pixel ownership: lowest-index active slot covering the pixel wins.
    always_comb begin
        pix_hit = 1'b0;
        pix_sel = '0;
        pix_ox  = '0;
        pix_oy  = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!pix_hit && active[SEL_W'(i)]
                && (pixelX >= top_x[SEL_W'(i)])
                && ({1'b0, pixelX} < ({1'b0, top_x[SEL_W'(i)]} + OBJ_W12))
                && (pixelY >= top_y[SEL_W'(i)])
                && ({1'b0, pixelY} < ({1'b0, top_y[SEL_W'(i)]} + OBJ_H12))) begin
                pix_hit = 1'b1;
                pix_sel = SEL_W'(i);
                pix_ox  = pixelX - top_x[SEL_W'(i)];
                pix_oy  = pixelY - top_y[SEL_W'(i)];
            end
        end
    end

    // Registered drawer inputs, owner index pipeline and skid pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            InsideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
            sel             <= '0;
            sel_d           <= '0;
            skidPulse       <= 1'b0;
        end else begin
            InsideRectangle <= pix_hit;
            offsetX         <= pix_ox;
            offsetY         <= pix_oy;
            sel             <= pix_sel;
            sel_d           <= sel;
            skidPulse       <= coll_fire;
        end
    end

endmodule

// File: tb/tb_oil_slick_controller.sv
// Directed bench for oil_slick_controller with a small slot/LFSR model.
module tb_oil_slick_controller;

    localparam int NS = 4;
    localparam int SP = 2;
    localparam int SH = 480;
    localparam int RL = 192;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sof = 1'b0;
    logic          en = 1'b0;
    logic [3:0]    speed = '0;
    logic [10:0]   px = '0;
    logic [10:0]   py = '0;
    logic          coll = 1'b0;
    logic          ins;
    logic [10:0]   ox;
    logic [10:0]   oy;
    logic          skid;
    logic [NS-1:0] mask;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    bit          exp_act [NS];
    int          exp_x [NS];
    int          exp_y [NS];
    int          exp_cnt;

    oil_slick_controller #(
        .NUM_SLOTS(NS), .OBJ_W(64), .OBJ_H(32), .SCREEN_H(SH),
        .ROAD_LEFT(RL), .SPAWN_PERIOD(SP)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(sof), .enable(en), .speed(speed),
        .pixelX(px), .pixelY(py), .oilCarCollision(coll),
        .InsideRectangle(ins), .offsetX(ox), .offsetY(oy),
        .skidPulse(skid), .activeMask(mask), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    always @(posedge clk) m_lfsr <= reset ? 16'hACE1 : lstep(m_lfsr);

    function automatic logic [NS-1:0] exp_mask();
        logic [NS-1:0] m;
        for (int i = 0; i < NS; i++) m[i] = exp_act[i];
        return m;
    endfunction

    // X a spawn would get if startOfFrame were raised at this negedge.
    function automatic int predict_x();
        logic [15:0] p;
        p = m_lfsr;
        for (int k = 0; k < NS + 1; k++) p = lstep(p);
        return RL + int'(p[7:0]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            exp_act[i] = 1'b0; exp_x[i] = 0; exp_y[i] = 0;
        end
        exp_cnt = 0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One frame; optionally delays startOfFrame until a due spawn lands in [lo,hi].
    task automatic do_frame(input int spd, input bit cons, input int lo, input int hi,
                            output logic b_mid, output logic b_end);
        bit nact [NS];
        int ny [NS];
        int free_slot;
        bit due;
        int sx;
        int waited;
        logic [15:0] sl;
        speed = 4'(spd);
        for (int i = 0; i < NS; i++) begin
            nact[i] = exp_act[i];
            ny[i]   = exp_y[i];
            if (nact[i]) begin
                if (ny[i] + spd >= SH) nact[i] = 1'b0;
                else ny[i] = ny[i] + spd;
            end
        end
        free_slot = -1;
        for (int i = NS - 1; i >= 0; i--) if (!nact[i]) free_slot = i;
        due = (exp_cnt == SP - 1);
        if (en && cons && due && free_slot >= 0) begin
            waited = 0;
            sx = predict_x();
            while ((sx < lo || sx > hi) && waited < 5000) begin
                @(negedge clk);
                waited++;
                sx = predict_x();
            end
            if (sx < lo || sx > hi) begin
                checks++; errors++;
                $display("FAIL spawn_wait got x=%0d required %0d..%0d", sx, lo, hi);
            end
        end
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        b_mid = busy;
        repeat (NS) @(negedge clk);
        sl = m_lfsr;
        @(negedge clk);
        b_end = busy;
        if (en) begin
            for (int i = 0; i < NS; i++) begin
                exp_act[i] = nact[i];
                exp_y[i]   = ny[i];
            end
            if (due) begin
                exp_cnt = 0;
                if (free_slot >= 0) begin
                    exp_act[free_slot] = 1'b1;
                    exp_y[free_slot]   = 0;
                    exp_x[free_slot]   = RL + int'(sl[7:0]);
                end
            end else begin
                exp_cnt++;
            end
        end
    endtask

    task automatic sample_px(input int x, input int y, output logic s_in,
                             output logic [10:0] s_ox, output logic [10:0] s_oy);
        px = 11'(x);
        py = 11'(y);
        @(negedge clk);
        s_in = ins; s_ox = ox; s_oy = oy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ins !== 1'b0) begin errors++; $display("FAIL rst_inside got %b required 0", ins); end
        checks++; if (ox !== 11'd0 || oy !== 11'd0) begin errors++; $display("FAIL rst_offsets got %0d,%0d required 0,0", ox, oy); end
        checks++; if (skid !== 1'b0) begin errors++; $display("FAIL rst_skid got %b required 0", skid); end
        checks++; if (mask !== 4'b0000) begin errors++; $display("FAIL rst_mask got %b required 0000", mask); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_spawn();
        logic bm, be, s_in;
        logic [10:0] s_ox, s_oy;
        en = 1'b1;
        do_frame(0, 0, 0, 0, bm, be);
        checks++; if (bm !== 1'b1) begin errors++; $display("FAIL busy_mid got %b required 1", bm); end
        checks++; if (be !== 1'b0) begin errors++; $display("FAIL busy_end got %b required 0", be); end
        checks++; if (mask !== 4'b0000) begin errors++; $display("FAIL f1_mask got %b required 0000", mask); end
        do_frame(0, 0, 0, 0, bm, be);
        checks++; if (mask !== 4'b0001) begin errors++; $display("FAIL f2_mask got %b required 0001", mask); end
        sample_px(exp_x[0], 0, s_in, s_ox, s_oy);
        checks++; if (s_in !== 1'b1 || s_ox !== 11'd0 || s_oy !== 11'd0) begin
            errors++; $display("FAIL spawn_corner got %b %0d %0d required 1 0 0 (x=%0d)", s_in, s_ox, s_oy, exp_x[0]); end
        sample_px(exp_x[0] + 64, 0, s_in, s_ox, s_oy);
        checks++; if (s_in !== 1'b0 || s_ox !== 11'd0) begin
            errors++; $display("FAIL spawn_right_edge got %b %0d required 0 0", s_in, s_ox); end
        do_frame(0, 0, 0, 0, bm, be);
        do_frame(0, 0, 0, 0, bm, be);
        checks++; if (mask !== 4'b0011) begin errors++; $display("FAIL f4_mask got %b required 0011", mask); end
    endtask

    task automatic test_pixel_sweep();
        logic bm, be, s_in;
        logic [10:0] s_ox, s_oy;
        pulse_reset();
        en = 1'b1;
        do_frame(0, 0, 0, 0, bm, be);
        do_frame(0, 1, 200, 200, bm, be);
        for (int f = 0; f < 10; f++) begin
            do_frame(10, 0, 0, 0, bm, be);
            checks++; if (mask !== exp_mask()) begin errors++; $display("FAIL sweep_mask f%0d got %b required %b", f, mask, exp_mask()); end
        end
        checks++; if (mask !== 4'b1111) begin errors++; $display("FAIL sweep_full got %b required 1111", mask); end
        sample_px(263, 131, s_in, s_ox, s_oy);
        checks++; if (s_in !== 1'b1 || s_ox !== 11'd63 || s_oy !== 11'd31) begin
            errors++; $display("FAIL px_263_131 got %b %0d %0d required 1 63 31", s_in, s_ox, s_oy); end
        sample_px(264, 131, s_in, s_ox, s_oy);
        checks++; if (s_in !== 1'b0 || s_ox !== 11'd0 || s_oy !== 11'd0) begin
            errors++; $display("FAIL px_264_131 got %b %0d %0d required 0 0 0", s_in, s_ox, s_oy); end
        sample_px(200, 100, s_in, s_ox, s_oy);
        checks++; if (s_in !== 1'b1 || s_ox !== 11'd0 || s_oy !== 11'd0) begin
            errors++; $display("FAIL px_200_100 got %b %0d %0d required 1 0 0", s_in, s_ox, s_oy); end
        sample_px(263, 132, s_in, s_ox, s_oy);
        checks++; if (s_in !== 1'b0) begin errors++; $display("FAIL px_263_132 got %b required 0", s_in); end
    endtask

    task automatic test_retire();
        logic bm, be, s_in;
        logic [10:0] s_ox, s_oy;
        int guard;
        guard = 0;
        while (exp_y[0] != 470 && guard < 60) begin
            do_frame(10, 0, 0, 0, bm, be);
            guard++;
            checks++; if (mask !== 4'b1111) begin errors++; $display("FAIL full_drop_mask g%0d got %b required 1111", guard, mask); end
        end
        if (exp_cnt != SP - 1) do_frame(0, 0, 0, 0, bm, be);
        do_frame(10, 0, 0, 0, bm, be);
        checks++; if (mask !== 4'b1111) begin errors++; $display("FAIL reuse_mask got %b required 1111", mask); end
        sample_px(exp_x[0] + 5, 3, s_in, s_ox, s_oy);
        checks++; if (s_in !== 1'b1 || s_ox !== 11'd5 || s_oy !== 11'd3) begin
            errors++; $display("FAIL reuse_slot0 got %b %0d %0d required 1 5 3", s_in, s_ox, s_oy); end
        do_frame(10, 0, 0, 0, bm, be);
        do_frame(0, 0, 0, 0, bm, be);
        checks++; if (mask !== 4'b1111) begin errors++; $display("FAIL drop_mask got %b required 1111", mask); end
        do_frame(10, 0, 0, 0, bm, be);
        checks++; if (mask !== 4'b1101) begin errors++; $display("FAIL retire_mask got %b required 1101", mask); end
        do_frame(0, 0, 0, 0, bm, be);
        checks++; if (mask !== 4'b1111) begin errors++; $display("FAIL respawn_mask got %b required 1111", mask); end
    endtask

    task automatic test_collision();
        logic bm, be, s_in;
        logic [10:0] s_ox, s_oy;
        int x0, x1, n;
        pulse_reset();
        en = 1'b1;
        do_frame(0, 0, 0, 0, bm, be);
        do_frame(0, 1, 192, 400, bm, be);
        x0 = exp_x[0];
        do_frame(0, 0, 0, 0, bm, be);
        do_frame(0, 1, x0 + 8, x0 + 20, bm, be);
        x1 = exp_x[1];
        checks++; if (mask !== 4'b0011) begin errors++; $display("FAIL coll_mask got %b required 0011", mask); end
        sample_px(x0 + 30, 10, s_in, s_ox, s_oy);
        checks++; if (s_in !== 1'b1 || s_ox !== 11'd30 || s_oy !== 11'd10) begin
            errors++; $display("FAIL overlap_owner got %b %0d %0d required 1 30 10", s_in, s_ox, s_oy); end
        repeat (3) @(negedge clk);
        coll = 1'b1;
        @(negedge clk);
        checks++; if (skid !== 1'b1) begin errors++; $display("FAIL skid_latency got %b required 1", skid); end
        n = (skid === 1'b1) ? 1 : 0;
        repeat (19) begin @(negedge clk); if (skid === 1'b1) n++; end
        coll = 1'b0;
        repeat (3) begin @(negedge clk); if (skid === 1'b1) n++; end
        checks++; if (n != 1) begin errors++; $display("FAIL skid_once got %0d pulses required 1", n); end
        n = 0;
        coll = 1'b1;
        repeat (10) begin @(negedge clk); if (skid === 1'b1) n++; end
        coll = 1'b0;
        repeat (3) begin @(negedge clk); if (skid === 1'b1) n++; end
        checks++; if (n != 0) begin errors++; $display("FAIL skid_repeat got %0d pulses required 0", n); end
        sample_px(x0 + 64, 10, s_in, s_ox, s_oy);
        checks++; if (s_in !== 1'b1 || s_ox !== 11'(x0 + 64 - x1) || s_oy !== 11'd10) begin
            errors++; $display("FAIL slot1_owner got %b %0d %0d required 1 %0d 10", s_in, s_ox, s_oy, x0 + 64 - x1); end
        repeat (3) @(negedge clk);
        n = 0;
        coll = 1'b1;
        repeat (10) begin @(negedge clk); if (skid === 1'b1) n++; end
        coll = 1'b0;
        repeat (3) begin @(negedge clk); if (skid === 1'b1) n++; end
        checks++; if (n != 1) begin errors++; $display("FAIL skid_slot1 got %0d pulses required 1", n); end
    endtask

    task automatic test_freeze();
        logic bm, be, s_in;
        logic [10:0] s_ox, s_oy;
        en = 1'b0;
        for (int f = 0; f < 5; f++) begin
            do_frame(7, 0, 0, 0, bm, be);
            checks++; if (bm !== 1'b0) begin errors++; $display("FAIL frozen_busy f%0d got %b required 0", f, bm); end
        end
        en = 1'b1;
        do_frame(0, 0, 0, 0, bm, be);
        checks++; if (mask !== 4'b0011) begin errors++; $display("FAIL frozen_cnt got %b required 0011", mask); end
        sample_px(exp_x[0], 0, s_in, s_ox, s_oy);
        checks++; if (s_in !== 1'b1 || s_ox !== 11'd0 || s_oy !== 11'd0) begin
            errors++; $display("FAIL frozen_pos got %b %0d %0d required 1 0 0", s_in, s_ox, s_oy); end
        do_frame(0, 0, 0, 0, bm, be);
        checks++; if (mask !== 4'b0111) begin errors++; $display("FAIL after_freeze_mask got %b required 0111", mask); end
    endtask

    task automatic test_reset_mid_update();
        logic bm, be, s_in;
        logic [10:0] s_ox, s_oy;
        en = 1'b1;
        speed = 4'd5;
        px = 11'(exp_x[0] + 1);
        py = 11'd6;
        @(negedge clk);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b required 1", busy); end
        checks++; if (ins !== 1'b1 || ox !== 11'd1 || oy !== 11'd1) begin
            errors++; $display("FAIL mid_slot0_moved got %b %0d %0d required 1 1 1", ins, ox, oy); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || mask !== 4'b0000) begin
            errors++; $display("FAIL mid_rst_state got busy=%b mask=%b required 0 0000", busy, mask); end
        checks++; if (ins !== 1'b0 || ox !== 11'd0 || oy !== 11'd0 || skid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_pix got %b %0d %0d %b required 0 0 0 0", ins, ox, oy, skid); end
        reset = 1'b0;
        model_reset();
        repeat (20) @(negedge clk);
        checks++; if (mask !== 4'b0000 || ins !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL post_rst_idle got mask=%b in=%b busy=%b required 0000 0 0", mask, ins, busy); end
        speed = 4'd0;
        do_frame(0, 0, 0, 0, bm, be);
        do_frame(0, 0, 0, 0, bm, be);
        checks++; if (mask !== 4'b0001) begin errors++; $display("FAIL post_rst_spawn got %b required 0001", mask); end
        sample_px(exp_x[0], 0, s_in, s_ox, s_oy);
        checks++; if (s_in !== 1'b1 || s_ox !== 11'd0 || s_oy !== 11'd0) begin
            errors++; $display("FAIL post_rst_lfsr got %b %0d %0d required 1 0 0 (x=%0d)", s_in, s_ox, s_oy, exp_x[0]); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_spawn();
        test_pixel_sweep();
        test_retire();
        test_collision();
        test_freeze();
        test_reset_mid_update();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
